gpio_in_debouncer: RTL and testbench



---
 rtl/gpio_pkg.sv | 13 +
 rtl/gpio_in_debouncer_bit.sv | 78 +++++++
 rtl/gpio_in_debouncer.sv | 36 +++
 tb/tb_gpio_in_debouncer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO input debouncer: per-bit FSM encoding and
// default timing constants (10 ms at 100 MHz).
package gpio_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } db_state_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEFAULT_CNT_W           = 24;

endpackage

// File: rtl/gpio_in_debouncer_bit.sv
// One input bit: two-flop synchroniser, counter-based debounce FSM, registered
// level, one-cycle rise/fall pulses and a sticky press latch.
module debounce_bit
  import gpio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic clock,
  input  logic reset_p,
  input  logic btn_raw,
  input  logic clear_latch,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic press_latched
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  db_state_e        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             level_d, rise_d, fall_d, latch_d;

  always_ff @(posedge clock) begin
    if (reset_p) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      state         <= STABLE;
      cnt           <= '0;
      level         <= 1'b0;
      rise_pulse    <= 1'b0;
      fall_pulse    <= 1'b0;
      press_latched <= 1'b0;
    end else begin
      s1            <= btn_raw;
      s2            <= s1;
      state         <= state_d;
      cnt           <= cnt_d;
      level         <= level_d;
      rise_pulse    <= rise_d;
      fall_pulse    <= fall_d;
      press_latched <= latch_d;
    end
  end

  // Counter only advances while s2 keeps disagreeing with the accepted level,
  // so it saturates at CNT_MAX and never wraps.
  always_comb begin
    state_d = state;
    cnt_d   = '0;
    level_d = level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    latch_d = press_latched & ~clear_latch;
    case (state)
      STABLE: begin
        if (s2 != level) state_d = COUNTING;
      end
      COUNTING: begin
        if (s2 == level) begin
          state_d = STABLE;
        end else if (cnt == CNT_MAX) begin
          state_d = STABLE;
          level_d = s2;
          rise_d  = s2;
          fall_d  = ~s2;
          if (s2) latch_d = 1'b1;  // set beats a coincident clear
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = STABLE;
    endcase
  end

endmodule

// File: rtl/gpio_in_debouncer.sv
// Debounces WIDTH raw button/switch pins into the processor's gpio_in bus;
// every bit is an independent debounce_bit instance.
module gpio_in_debouncer
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset_p,
  input  logic [WIDTH-1:0] btn_raw,
  input  logic [WIDTH-1:0] clear_latch,
  output logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] press_latched
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clock         (clock),
      .reset_p       (reset_p),
      .btn_raw       (btn_raw[i]),
      .clear_latch   (clear_latch[i]),
      .level         (gpio_in[i]),
      .rise_pulse    (rise_pulse[i]),
      .fall_pulse    (fall_pulse[i]),
      .press_latched (press_latched[i])
    );
  end

endmodule

// File: tb/tb_gpio_in_debouncer.sv
// Directed bench for gpio_in_debouncer with DEBOUNCE_CYCLES=4: a level first
// sampled at edge k is committed at edge k+6.
module tb_gpio_in_debouncer;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset_p;
  logic [W-1:0] btn_raw, clear_latch;
  logic [W-1:0] gpio_in, rise_pulse, fall_pulse, press_latched;

  int n_chk  = 0;
  int n_fail = 0;

  gpio_in_debouncer #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clock         (clock),
    .reset_p       (reset_p),
    .btn_raw       (btn_raw),
    .clear_latch   (clear_latch),
    .gpio_in       (gpio_in),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .press_latched (press_latched)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step one rising edge; sample 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Run n edges; gpio_in switches g0->g1 at edge index 'at' (-1 = never),
  // where rise/fall equal r/f for that single edge only.
  task automatic watch(input int n, input int at, input logic [W-1:0] g0,
                       input logic [W-1:0] g1, input logic [W-1:0] r,
                       input logic [W-1:0] f);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("gpio@%0d", i), 32'(gpio_in), 32'((at >= 0 && i >= at) ? g1 : g0));
      chk($sformatf("rise@%0d", i), 32'(rise_pulse), 32'((i == at) ? r : 4'b0000));
      chk($sformatf("fall@%0d", i), 32'(fall_pulse), 32'((i == at) ? f : 4'b0000));
    end
  endtask

  initial begin
    reset_p     = 1'b1;
    btn_raw     = '0;
    clear_latch = '0;
    repeat (3) tick();
    reset_p = 1'b0;
    chk("rst_gpio",  32'(gpio_in),       32'h0);
    chk("rst_rise",  32'(rise_pulse),    32'h0);
    chk("rst_fall",  32'(fall_pulse),    32'h0);
    chk("rst_latch", 32'(press_latched), 32'h0);

    // Quiet inputs: nothing moves.
    watch(20, -1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("quiet_latch", 32'(press_latched), 32'h0);

    // Bit 0 press: commit at edge k+6.
    btn_raw = 4'b0001;
    watch(8, 6, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    chk("b0_latch", 32'(press_latched), 32'b0001);

    // Bit 1 glitch sampled on 4 edges: rejected.
    btn_raw = 4'b0011;
    watch(4, -1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    btn_raw = 4'b0001;
    watch(10, -1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    chk("glitch_latch", 32'(press_latched), 32'b0001);

    // Bit 1 held 6 edges: accepted at k+6, then the release falls 6 edges later.
    btn_raw = 4'b0011;
    watch(6, -1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    btn_raw = 4'b0001;
    watch(3, 0, 4'b0001, 4'b0011, 4'b0010, 4'b0000);
    watch(5, 3, 4'b0011, 4'b0001, 4'b0000, 4'b0010);
    chk("b1_latch", 32'(press_latched), 32'b0011);

    // Bit 2 press, release, then clear of its latch.
    btn_raw = 4'b0101;
    watch(8, 6, 4'b0001, 4'b0101, 4'b0100, 4'b0000);
    chk("b2_latch_set", 32'(press_latched), 32'b0111);
    btn_raw = 4'b0001;
    watch(8, 6, 4'b0101, 4'b0001, 4'b0000, 4'b0100);
    chk("b2_latch_hold", 32'(press_latched), 32'b0111);
    tick();
    chk("b2_latch_hold2", 32'(press_latched), 32'b0111);
    clear_latch = 4'b0100;
    tick();
    clear_latch = 4'b0000;
    chk("b2_latch_clr", 32'(press_latched), 32'b0011);
    tick();
    chk("b2_latch_stay", 32'(press_latched), 32'b0011);

    // Bit 3: clear coincides with the rise edge, set wins.
    btn_raw = 4'b1001;
    watch(6, -1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    clear_latch = 4'b1000;
    tick();
    clear_latch = 4'b0000;
    chk("b3_gpio",  32'(gpio_in),       32'b1001);
    chk("b3_rise",  32'(rise_pulse),    32'b1000);
    chk("b3_latch", 32'(press_latched), 32'b1011);
    tick();
    chk("b3_rise_off",  32'(rise_pulse),    32'h0);
    chk("b3_latch_hold", 32'(press_latched), 32'b1011);

    // Reset clears everything.
    btn_raw = 4'b0000;
    reset_p = 1'b1;
    repeat (2) tick();
    reset_p = 1'b0;
    chk("rst2_gpio",  32'(gpio_in),       32'h0);
    chk("rst2_latch", 32'(press_latched), 32'h0);

    // Bit 0 counts to cnt=2, reset discards it; recount starts from scratch.
    btn_raw = 4'b0001;
    watch(5, -1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    reset_p = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("midrst_gpio%0d", i), 32'(gpio_in),    32'h0);
      chk($sformatf("midrst_rise%0d", i), 32'(rise_pulse), 32'h0);
    end
    reset_p = 1'b0;
    watch(8, 6, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    chk("postrst_latch", 32'(press_latched), 32'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
